// File: rtl/tcheck_pkg.sv
// Shared types and constants for the conditioned-setup stimulus generator.
//   tcheck_state_t : sequencing states of the generator FSM
//   COND_*         : encodings of the cond_mode input
package tcheck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } tcheck_state_t;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_ALT    = 2'd1;
  localparam logic [1:0] COND_NEVER  = 2'd2;

endpackage

// File: rtl/tcheck_phase_cnt.sv
// Phase counter for one sclk half-period.
//   clk, rst : fast clock, async active-high reset
//   clr      : synchronous clear to 0 (priority over en)
//   en       : advance; wraps to 0 after hp-1
//   hp       : effective half-period (>= 1 whenever en is used)
//   phase    : current phase value
//   last     : phase == hp-1
module tcheck_phase_cnt #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] hp,
  output logic [PERIOD_W-1:0] phase,
  output logic                last
);

  assign last = (phase == hp - PERIOD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= last ? '0 : phase + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/tcheck_stim_gen.sv
// Stimulus generator for $setup(data, posedge sclk &&& cond, N) checks.
// Produces a slow strobe sclk (period 2*hp clk cycles), a data signal that
// toggles so clk cycles before each sclk rise, and a condition output.
//   clk, rst   : fast clock, async active-high reset
//   start      : begin a run (IDLE only); stop : synchronous abort to IDLE
//   half_per   : sclk half-period in clk cycles (0 treated as 1)
//   setup_off  : data-to-sclk-rise distance in clk cycles (clamped to hp)
//   cond_mode  : 0 always 1, 1 alternating from 1, 2/3 always 0
//   count      : number of sclk rises per run
//   sclk, data, cond : generated stimulus (registered)
//   busy, done : run in progress / one-cycle completion pulse
//   edge_cnt   : sclk rises generated in current or last run
module tcheck_stim_gen
  import tcheck_pkg::*;
#(
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] half_per,
  input  logic [PERIOD_W-1:0] setup_off,
  input  logic [1:0]          cond_mode,
  input  logic [COUNT_W-1:0]  count,
  output logic                sclk,
  output logic                data,
  output logic                cond,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  edge_cnt
);

  tcheck_state_t state, nxt;

  logic [PERIOD_W-1:0] hp_r, tgt_r;
  logic [1:0]          mode_r;
  logic [COUNT_W-1:0]  count_r;

  logic [PERIOD_W-1:0] in_hp, in_so, in_tgt;
  logic [PERIOD_W-1:0] phase;
  logic [PERIOD_W:0]   phase_nx;
  logic                last;

  logic pclr, pen, load, tog, rise, cnt_clr, cond_nx;

  // Effective parameters derived from the inputs at start time. The toggle
  // target is the LOW-phase value hp-so on whose entry data flips; a target
  // equal to hp means the flip coincides with the sclk rise.
  always_comb begin
    in_hp  = (half_per == '0) ? PERIOD_W'(1) : half_per;
    in_so  = (setup_off > in_hp) ? in_hp : setup_off;
    in_tgt = in_hp - in_so;
  end

  assign phase_nx = {1'b0, phase} + (PERIOD_W+1)'(1);

  tcheck_phase_cnt #(.PERIOD_W(PERIOD_W)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (pclr),
    .en    (pen),
    .hp    (hp_r),
    .phase (phase),
    .last  (last)
  );

  always_comb begin
    case (mode_r)
      COND_ALWAYS: cond_nx = 1'b1;
      COND_ALT:    cond_nx = ~edge_cnt[0];
      default:     cond_nx = 1'b0;
    endcase
  end

  always_comb begin
    nxt     = state;
    pclr    = 1'b0;
    pen     = 1'b0;
    load    = 1'b0;
    tog     = 1'b0;
    rise    = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      IDLE: begin
        pclr = 1'b1;
        if (start) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          if (count == '0) begin
            nxt = DONE;
          end else begin
            nxt = LOW;
            tog = (in_tgt == '0);
          end
        end
      end
      LOW: begin
        if (stop) begin
          nxt  = IDLE;
          pclr = 1'b1;
        end else begin
          pen = 1'b1;
          tog = (phase_nx == {1'b0, tgt_r});
          if (last) begin
            nxt  = HIGH;
            rise = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          nxt  = IDLE;
          pclr = 1'b1;
        end else begin
          pen = 1'b1;
          if (last) begin
            if (edge_cnt == count_r) begin
              nxt = DONE;
            end else begin
              nxt = LOW;
              tog = (tgt_r == '0);
            end
          end
        end
      end
      DONE: begin
        nxt  = IDLE;
        pclr = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data     <= 1'b0;
      cond     <= 1'b0;
      edge_cnt <= '0;
      hp_r     <= PERIOD_W'(1);
      tgt_r    <= '0;
      mode_r   <= '0;
      count_r  <= '0;
    end else begin
      state <= nxt;
      sclk  <= (nxt == HIGH);
      busy  <= (nxt == LOW) || (nxt == HIGH);
      done  <= (nxt == DONE);
      if (load) begin
        hp_r    <= in_hp;
        tgt_r   <= in_tgt;
        mode_r  <= cond_mode;
        count_r <= count;
      end
      if (tog) data <= ~data;
      if (rise) cond <= cond_nx;
      if (cnt_clr) edge_cnt <= '0;
      else if (rise) edge_cnt <= edge_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tcheck_stim_gen.sv
// Directed bench for tcheck_stim_gen. Each run is traced cycle by cycle after
// the accepting edge (k=0 is the edge that samples start) and the recorded
// sclk rise / data toggle / done positions are compared to hand-computed values.
module tb_tcheck_stim_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  half_per = '0;
  logic [7:0]  setup_off = '0;
  logic [1:0]  cond_mode = '0;
  logic [15:0] count = '0;
  logic        sclk, data, cond, busy, done;
  logic [15:0] edge_cnt;

  int errors = 0;
  int checks = 0;

  int n_rise, n_tog, n_done, done_k;
  int rise_k[8];
  int tog_k[8];
  int cond_r[8];
  logic [63:0] sclk_tr, busy_tr;

  tcheck_stim_gen #(.PERIOD_W(8), .COUNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .half_per  (half_per),
    .setup_off (setup_off),
    .cond_mode (cond_mode),
    .count     (count),
    .sclk      (sclk),
    .data      (data),
    .cond      (cond),
    .busy      (busy),
    .done      (done),
    .edge_cnt  (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int hp, input int so, input int mode, input int cnt,
                     input int budget, input int stop_at, input int spulse_at);
    logic pd, ps;
    n_rise = 0; n_tog = 0; n_done = 0; done_k = -1;
    for (int i = 0; i < 8; i++) begin
      rise_k[i] = -1; tog_k[i] = -1; cond_r[i] = -1;
    end
    sclk_tr = '0; busy_tr = '0;
    half_per  = 8'(hp);
    setup_off = 8'(so);
    cond_mode = 2'(mode);
    count     = 16'(cnt);
    pd = data; ps = sclk;
    start = 1'b1;
    for (int k = 0; k <= budget; k++) begin
      @(posedge clk); #1;
      start = (k == spulse_at);
      stop  = (k == stop_at);
      if (sclk && !ps) begin
        if (n_rise < 8) begin rise_k[n_rise] = k; cond_r[n_rise] = int'(cond); end
        n_rise++;
      end
      if (data != pd) begin
        if (n_tog < 8) tog_k[n_tog] = k;
        n_tog++;
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k < 64) begin sclk_tr[k] = sclk; busy_tr[k] = busy; end
      pd = data; ps = sclk;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_cond", int'(cond), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ecnt", int'(edge_cnt), 0);
    @(negedge clk); rst = 1'b0;

    // hp=4 so=2 count=3 mode 0: rises at 4,12,20; toggles 2 before each
    run(4, 2, 0, 3, 30, -1, -1);
    chk("t1_busy0", int'(busy_tr[0]), 1);
    chk("t1_nrise", n_rise, 3);
    chk("t1_rise0", rise_k[0], 4);
    chk("t1_rise1", rise_k[1], 12);
    chk("t1_rise2", rise_k[2], 20);
    chk("t1_ntog", n_tog, 3);
    chk("t1_tog0", tog_k[0], 2);
    chk("t1_tog1", tog_k[1], 10);
    chk("t1_tog2", tog_k[2], 18);
    chk("t1_cond", cond_r[0] + cond_r[1] + cond_r[2], 3);
    chk("t1_donek", done_k, 24);
    chk("t1_ndone", n_done, 1);
    chk("t1_busyD", int'(busy_tr[24]), 0);
    chk("t1_ecnt", int'(edge_cnt), 3);

    // mode 2 after a mode-0 run: cond falls to 0 at each rise
    run(2, 1, 2, 2, 10, -1, -1);
    chk("m2_cond0", cond_r[0], 0);
    chk("m2_cond1", cond_r[1], 0);
    chk("m2_donek", done_k, 8);

    // zero setup margin: data toggles on the sclk rise edge
    run(3, 0, 0, 2, 14, -1, -1);
    chk("s0_rise0", rise_k[0], 3);
    chk("s0_tog0", tog_k[0], 3);
    chk("s0_rise1", rise_k[1], 9);
    chk("s0_tog1", tog_k[1], 9);
    chk("s0_donek", done_k, 12);

    // setup_off clamped to hp: toggle on first LOW cycle
    run(3, 9, 0, 2, 14, -1, -1);
    chk("sc_tog0", tog_k[0], 0);
    chk("sc_tog1", tog_k[1], 6);
    chk("sc_rise0", rise_k[0], 3);
    chk("sc_rise1", rise_k[1], 9);

    // alternating cond: 1,0,1,0
    run(2, 1, 1, 4, 18, -1, -1);
    chk("ca_cond0", cond_r[0], 1);
    chk("ca_cond1", cond_r[1], 0);
    chk("ca_cond2", cond_r[2], 1);
    chk("ca_cond3", cond_r[3], 0);
    chk("ca_rise3", rise_k[3], 14);
    chk("ca_donek", done_k, 16);
    chk("ca_ecnt", int'(edge_cnt), 4);

    // count=0: done in the cycle after the accepting edge, no sclk
    run(4, 2, 0, 0, 6, -1, -1);
    chk("c0_donek", done_k, 0);
    chk("c0_ndone", n_done, 1);
    chk("c0_nrise", n_rise, 0);
    chk("c0_busy0", int'(busy_tr[0]), 0);
    chk("c0_ecnt", int'(edge_cnt), 0);

    // half_per=0 behaves as 1
    run(0, 0, 0, 2, 6, -1, -1);
    chk("h0_rise0", rise_k[0], 1);
    chk("h0_rise1", rise_k[1], 3);
    chk("h0_donek", done_k, 4);

    // stop during second HIGH (k=9..11), stray start at k=5
    run(3, 1, 1, 5, 16, 10, 5);
    chk("sp_nrise", n_rise, 2);
    chk("sp_rise1", rise_k[1], 9);
    chk("sp_sclk10", int'(sclk_tr[10]), 1);
    chk("sp_sclk11", int'(sclk_tr[11]), 0);
    chk("sp_busy11", int'(busy_tr[11]), 0);
    chk("sp_ndone", n_done, 0);
    chk("sp_ntog", n_tog, 2);
    chk("sp_cond", int'(cond), 0);
    chk("sp_ecnt", int'(edge_cnt), 2);

    // async reset mid-LOW (k=9 of an hp=4 run)
    half_per = 8'd4; setup_off = 8'd2; cond_mode = 2'd0; count = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("ar_pre_sclk", int'(sclk), 0);
    chk("ar_pre_busy", int'(busy), 1);
    chk("ar_pre_ecnt", int'(edge_cnt), 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_sclk", int'(sclk), 0);
    chk("ar_data", int'(data), 0);
    chk("ar_cond", int'(cond), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_ecnt", int'(edge_cnt), 0);
    @(negedge clk); rst = 1'b0;

    run(4, 2, 0, 3, 30, -1, -1);
    chk("rr_rise0", rise_k[0], 4);
    chk("rr_tog0", tog_k[0], 2);
    chk("rr_donek", done_k, 24);
    chk("rr_ecnt", int'(edge_cnt), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
